// File: rtl/peripheral_fifo_uart.sv
// peripheral_fifo_uart: MMIO timer, LED/switch/7-seg registers and FIFO-buffered UART front-end.
// Rev 1.0
`default_nettype none

module peripheral_fifo_uart #(
  parameter logic [31:0] BASE_ADDR  = 32'h40000000,
  parameter int          TIMER_W    = 32,
  parameter int          FIFO_DEPTH = 8,
  parameter int          LED_W      = 8,
  parameter int          SW_W       = 8,
  parameter int          DIGI_W     = 12
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [LED_W-1:0]  led,
  input  logic [SW_W-1:0]   switch,
  output logic [DIGI_W-1:0] digi,
  output logic              irqout,
  input  logic              PC_31,
  output logic [7:0]        tx_data,
  output logic              tx_en,
  input  logic              tx_status,
  input  logic [7:0]        rx_data,
  input  logic              rx_status
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_WAIT_BUSY = 2'd1,
    TX_WAIT_DONE = 2'd2
  } tx_state_e;

  tx_state_e tx_state_q, tx_state_d;

  logic [TIMER_W-1:0] th_q, th_d, tl_q, tl_d;
  logic [2:0]         tcon_q, tcon_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [DIGI_W-1:0]  digi_q, digi_d;
  logic [1:0]         ie_q, ie_d;
  logic               rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
  logic [AW-1:0]      txf_wp_q, txf_wp_d, txf_rp_q, txf_rp_d;
  logic [AW-1:0]      rxf_wp_q, rxf_wp_d, rxf_rp_q, rxf_rp_d;
  logic [CW-1:0]      txf_cnt_q, txf_cnt_d, rxf_cnt_q, rxf_cnt_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_en_q, tx_en_d;
  logic               irq_q, irq_d;
  logic               rx_stat_q;

  logic [7:0] txf_mem [FIFO_DEPTH];
  logic [7:0] rxf_mem [FIFO_DEPTH];

  logic [31:0] off;
  logic sel_th, sel_tl, sel_tcon, sel_led, sel_digi, sel_txd, sel_rxd, sel_stat, sel_ie;
  logic tx_full, tx_nonempty, tx_push, tx_drop, tx_pop, tx_idle;
  logic rx_full, rx_nonempty, rx_rise, rx_push, rx_drop, rx_pop;

  assign off      = addr - BASE_ADDR;
  assign sel_th   = (off == 32'h00);
  assign sel_tl   = (off == 32'h04);
  assign sel_tcon = (off == 32'h08);
  assign sel_led  = (off == 32'h0C);
  assign sel_digi = (off == 32'h14);
  assign sel_txd  = (off == 32'h18);
  assign sel_rxd  = (off == 32'h1C);
  assign sel_stat = (off == 32'h20);
  assign sel_ie   = (off == 32'h24);

  assign tx_full     = (txf_cnt_q == FULL_CNT);
  assign tx_nonempty = (txf_cnt_q != '0);
  assign tx_push     = wr & sel_txd & ~tx_full;
  assign tx_drop     = wr & sel_txd & tx_full;
  assign tx_idle     = ~tx_nonempty & (tx_state_q == TX_IDLE) & tx_status;

  // A pop frees a slot in the same cycle, so a full RX FIFO can still accept
  assign rx_full     = (rxf_cnt_q == FULL_CNT);
  assign rx_nonempty = (rxf_cnt_q != '0);
  assign rx_rise     = rx_status & ~rx_stat_q;
  assign rx_pop      = rd & sel_rxd & rx_nonempty;
  assign rx_push     = rx_rise & (~rx_full | rx_pop);
  assign rx_drop     = rx_rise & rx_full & ~rx_pop;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_nonempty && tx_status) begin
          tx_pop     = 1'b1;
          tx_state_d = TX_WAIT_BUSY;
        end
      end
      TX_WAIT_BUSY: if (!tx_status) tx_state_d = TX_WAIT_DONE;
      TX_WAIT_DONE: if (tx_status) tx_state_d = TX_IDLE;
      default:      tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    led_d  = led_q;
    digi_d = digi_q;
    ie_d   = ie_q;
    if (tcon_q[0]) begin
      if (&tl_q) begin
        tl_d = th_q;
        if (tcon_q[1]) tcon_d[2] = 1'b1;
      end else begin
        tl_d = tl_q + TIMER_W'(1);
      end
    end
    // Bus writes override the timer's own update
    if (wr && sel_th)   th_d   = wdata[TIMER_W-1:0];
    if (wr && sel_tl)   tl_d   = wdata[TIMER_W-1:0];
    if (wr && sel_tcon) tcon_d = wdata[2:0];
    if (wr && sel_led)  led_d  = wdata[LED_W-1:0];
    if (wr && sel_digi) digi_d = wdata[DIGI_W-1:0];
    if (wr && sel_ie)   ie_d   = wdata[1:0];

    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
    if (wr && sel_stat && wdata[4]) tx_ovf_d = 1'b0;
    if (wr && sel_stat && wdata[3]) rx_ovf_d = 1'b0;
    if (tx_drop) tx_ovf_d = 1'b1;
    if (rx_drop) rx_ovf_d = 1'b1;

    txf_wp_d  = tx_push ? txf_wp_q + AW'(1) : txf_wp_q;
    txf_rp_d  = tx_pop  ? txf_rp_q + AW'(1) : txf_rp_q;
    txf_cnt_d = txf_cnt_q;
    if (tx_push && !tx_pop)      txf_cnt_d = txf_cnt_q + CW'(1);
    else if (!tx_push && tx_pop) txf_cnt_d = txf_cnt_q - CW'(1);

    rxf_wp_d  = rx_push ? rxf_wp_q + AW'(1) : rxf_wp_q;
    rxf_rp_d  = rx_pop  ? rxf_rp_q + AW'(1) : rxf_rp_q;
    rxf_cnt_d = rxf_cnt_q;
    if (rx_push && !rx_pop)      rxf_cnt_d = rxf_cnt_q + CW'(1);
    else if (!rx_push && rx_pop) rxf_cnt_d = rxf_cnt_q - CW'(1);

    tx_en_d   = tx_pop;
    tx_data_d = tx_pop ? txf_mem[txf_rp_q] : tx_data_q;
    irq_d     = ~PC_31 & ((tcon_q[1] & tcon_q[2]) | (ie_q[0] & rx_nonempty) | (ie_q[1] & tx_idle));
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      th_q       <= '0;
      tl_q       <= '0;
      tcon_q     <= '0;
      led_q      <= '0;
      digi_q     <= '0;
      ie_q       <= '0;
      rx_ovf_q   <= 1'b0;
      tx_ovf_q   <= 1'b0;
      txf_wp_q   <= '0;
      txf_rp_q   <= '0;
      txf_cnt_q  <= '0;
      rxf_wp_q   <= '0;
      rxf_rp_q   <= '0;
      rxf_cnt_q  <= '0;
      tx_data_q  <= '0;
      tx_en_q    <= 1'b0;
      irq_q      <= 1'b0;
      rx_stat_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      th_q       <= th_d;
      tl_q       <= tl_d;
      tcon_q     <= tcon_d;
      led_q      <= led_d;
      digi_q     <= digi_d;
      ie_q       <= ie_d;
      rx_ovf_q   <= rx_ovf_d;
      tx_ovf_q   <= tx_ovf_d;
      txf_wp_q   <= txf_wp_d;
      txf_rp_q   <= txf_rp_d;
      txf_cnt_q  <= txf_cnt_d;
      rxf_wp_q   <= rxf_wp_d;
      rxf_rp_q   <= rxf_rp_d;
      rxf_cnt_q  <= rxf_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_en_q    <= tx_en_d;
      irq_q      <= irq_d;
      rx_stat_q  <= rx_status;
    end
  end

  always_ff @(posedge sysclk) begin
    if (tx_push) txf_mem[txf_wp_q] <= wdata[7:0];
    if (rx_push) rxf_mem[rxf_wp_q] <= rx_data;
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (off)
        32'h00:  rdata = 32'(th_q);
        32'h04:  rdata = 32'(tl_q);
        32'h08:  rdata = {29'd0, tcon_q};
        32'h0C:  rdata = 32'(led_q);
        32'h10:  rdata = 32'(switch);
        32'h14:  rdata = 32'(digi_q);
        32'h1C:  rdata = rx_nonempty ? {24'd0, rxf_mem[rxf_rp_q]} : 32'd0;
        32'h20:  rdata = {8'd0, 8'(txf_cnt_q), 8'(rxf_cnt_q), 3'd0,
                          tx_ovf_q, rx_ovf_q, tx_idle, ~tx_full, rx_nonempty};
        32'h24:  rdata = {30'd0, ie_q};
        default: rdata = '0;
      endcase
    end
  end

  assign led     = led_q;
  assign digi    = digi_q;
  assign irqout  = irq_q;
  assign tx_data = tx_data_q;
  assign tx_en   = tx_en_q;

endmodule

`default_nettype wire

// File: tb/tb_peripheral_fifo_uart.sv
// tb_peripheral_fifo_uart: directed register vectors plus multi-cycle timer, TX, RX and IRQ sequences.
// Rev 1.0
`default_nettype none

module tb_peripheral_fifo_uart;

  localparam logic [31:0] BASE = 32'h40000000;

  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = BASE;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic [7:0]  led;
  logic [7:0]  switch = 8'h5A;
  logic [11:0] digi;
  logic        irqout;
  logic        PC_31 = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_status = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_status = 1'b0;

  peripheral_fifo_uart dut (
    .sysclk(sysclk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .led(led), .switch(switch), .digi(digi), .irqout(irqout),
    .PC_31(PC_31), .tx_data(tx_data), .tx_en(tx_en), .tx_status(tx_status),
    .rx_data(rx_data), .rx_status(rx_status)
  );

  always #5 sysclk = ~sysclk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sender model: busy for 5 cycles after each tx_en, or held busy on request
  logic [7:0] sent_q[$];
  int         busy_cnt = 0;
  bit         hold_busy = 1'b0;
  initial begin
    forever begin
      @(negedge sysclk);
      if (tx_en === 1'b1) begin
        sent_q.push_back(tx_data);
        busy_cnt = 5;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      tx_status = (busy_cnt == 0) && !hold_busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Tasks are entered and left on a falling clock edge
  task automatic bus_write(input logic [31:0] o, input logic [31:0] d);
    addr = BASE + o; wdata = d; wr = 1'b1;
    @(negedge sysclk);
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] o, output logic [31:0] d);
    addr = BASE + o; rd = 1'b1;
    #1 d = rdata;
    @(negedge sysclk);
    rd = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] v);
    rx_data = v; rx_status = 1'b1;
    @(negedge sysclk);
    rx_status = 1'b0;
    @(negedge sysclk);
  endtask

  task automatic wait_tx_idle(input int limit, input string name);
    logic [31:0] s;
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      bus_read(32'h20, s);
      if (s[2]) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  typedef struct {
    int          op;   // 0 read+check, 1 write, 2 rd low + check
    logic [31:0] off;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input int op, input logic [31:0] o, input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.op = op; v.off = o; v.data = d; v.exp = e;
    return v;
  endfunction

  initial begin
    vec_t        vecs[$];
    logic [31:0] v;
    bit          seen;

    vecs.push_back(mk(0, 32'h00, 0, 32'h0));
    vecs.push_back(mk(0, 32'h04, 0, 32'h0));
    vecs.push_back(mk(0, 32'h08, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0C, 0, 32'h0));
    vecs.push_back(mk(0, 32'h10, 0, 32'h5A));
    vecs.push_back(mk(0, 32'h14, 0, 32'h0));
    vecs.push_back(mk(0, 32'h20, 0, 32'h6));
    vecs.push_back(mk(0, 32'h24, 0, 32'h0));
    vecs.push_back(mk(1, 32'h00, 32'h12345678, 0));
    vecs.push_back(mk(0, 32'h00, 0, 32'h12345678));
    vecs.push_back(mk(1, 32'h0C, 32'h1A5, 0));
    vecs.push_back(mk(0, 32'h0C, 0, 32'hA5));
    vecs.push_back(mk(1, 32'h14, 32'hABCD, 0));
    vecs.push_back(mk(0, 32'h14, 0, 32'hBCD));
    vecs.push_back(mk(1, 32'h24, 32'hFF, 0));
    vecs.push_back(mk(0, 32'h24, 0, 32'h3));
    vecs.push_back(mk(1, 32'h24, 32'h0, 0));
    vecs.push_back(mk(1, 32'h08, 32'hF8, 0));
    vecs.push_back(mk(0, 32'h08, 0, 32'h0));
    vecs.push_back(mk(1, 32'h10, 32'hFF, 0));
    vecs.push_back(mk(0, 32'h10, 0, 32'h5A));
    vecs.push_back(mk(1, 32'h1C, 32'h77, 0));
    vecs.push_back(mk(0, 32'h20, 0, 32'h6));
    vecs.push_back(mk(0, 32'h28, 0, 32'h0));
    vecs.push_back(mk(2, 32'h0C, 0, 32'h0));

    repeat (3) @(negedge sysclk);
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_irqout", 32'(irqout), 32'd0);
    reset = 1'b0;
    @(negedge sysclk);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_digi", 32'(digi), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        0: begin
          bus_read(vecs[i].off, v);
          check($sformatf("vec%0d", i), v, vecs[i].exp);
        end
        1: bus_write(vecs[i].off, vecs[i].data);
        default: begin
          addr = BASE + vecs[i].off; rd = 1'b0;
          #1 check($sformatf("vec%0d", i), rdata, vecs[i].exp);
          @(negedge sysclk);
        end
      endcase
    end
    check("led_port", 32'(led), 32'hA5);
    check("digi_port", 32'(digi), 32'hBCD);

    // Timer auto-reload and interrupt masking
    bus_write(32'h00, 32'hFFFFFFFC);
    bus_write(32'h04, 32'hFFFFFFFE);
    bus_write(32'h08, 32'h3);
    addr = BASE + 32'h04; rd = 1'b1;
    #1 check("tl_c0", rdata, 32'hFFFFFFFE);
    @(negedge sysclk);
    check("tl_c1", rdata, 32'hFFFFFFFF);
    @(negedge sysclk);
    check("tl_wrap", rdata, 32'hFFFFFFFC);
    check("irq_lat0", 32'(irqout), 32'd0);
    @(negedge sysclk);
    check("irq_timer", 32'(irqout), 32'd1);
    addr = BASE + 32'h08;
    #1 check("tcon_flag", rdata, 32'h7);
    rd = 1'b0;
    PC_31 = 1'b1;
    @(negedge sysclk);
    check("irq_pc31_mask", 32'(irqout), 32'd0);
    PC_31 = 1'b0;
    bus_write(32'h08, 32'h0);
    repeat (2) @(negedge sysclk);
    check("irq_timer_off", 32'(irqout), 32'd0);

    // TX ordering and idle status
    sent_q.delete();
    bus_write(32'h18, 32'h41);
    bus_write(32'h18, 32'h42);
    bus_write(32'h18, 32'h43);
    bus_read(32'h20, v);
    check("tx_busy_stat", 32'(v[2]), 32'd0);
    wait_tx_idle(200, "tx_idle_timeout");
    check("tx_sent_n", 32'(sent_q.size()), 32'd3);
    if (sent_q.size() == 3) begin
      check("tx_b0", 32'(sent_q[0]), 32'h41);
      check("tx_b1", 32'(sent_q[1]), 32'h42);
      check("tx_b2", 32'(sent_q[2]), 32'h43);
    end

    // TX overflow with sender held busy
    hold_busy = 1'b1;
    repeat (2) @(negedge sysclk);
    for (int i = 0; i < 9; i++) bus_write(32'h18, 32'h50 + 32'(i));
    bus_read(32'h20, v);
    check("tx_ovf_stat", v, 32'h00080010);
    bus_write(32'h20, 32'h10);
    bus_read(32'h20, v);
    check("tx_ovf_clr", v, 32'h00080000);
    sent_q.delete();
    hold_busy = 1'b0;
    wait_tx_idle(400, "tx_drain_timeout");
    check("tx_drain_n", 32'(sent_q.size()), 32'd8);
    if (sent_q.size() == 8)
      for (int i = 0; i < 8; i++) check($sformatf("tx_drain%0d", i), 32'(sent_q[i]), 32'h50 + 32'(i));

    // RX overflow and drain
    for (int i = 1; i <= 9; i++) rx_pulse(8'(i));
    bus_read(32'h20, v);
    check("rx_ovf_stat", v, 32'h0000080F);
    for (int i = 1; i <= 8; i++) begin
      bus_read(32'h1C, v);
      check($sformatf("rx_rd%0d", i), v, 32'(i));
    end
    bus_read(32'h1C, v);
    check("rx_rd_empty", v, 32'h0);
    bus_read(32'h20, v);
    check("rx_empty_stat", v, 32'h0000000E);
    bus_write(32'h20, 32'h08);
    bus_read(32'h20, v);
    check("rx_ovf_clr", v, 32'h6);

    // Full RX FIFO: push and pop in the same cycle
    for (int i = 0; i < 8; i++) rx_pulse(8'h11 + 8'(i));
    bus_read(32'h20, v);
    check("rx_full_stat", v, 32'h00000807);
    addr = BASE + 32'h1C; rd = 1'b1; rx_data = 8'h99; rx_status = 1'b1;
    #1 v = rdata;
    @(negedge sysclk);
    rd = 1'b0; rx_status = 1'b0;
    check("rx_sim_head", v, 32'h11);
    bus_read(32'h20, v);
    check("rx_sim_stat", v, 32'h00000807);
    for (int i = 0; i < 7; i++) begin
      bus_read(32'h1C, v);
      check($sformatf("rx_sim%0d", i), v, 32'h12 + 32'(i));
    end
    bus_read(32'h1C, v);
    check("rx_sim_new", v, 32'h99);

    // RX interrupt latency
    bus_write(32'h24, 32'h1);
    @(negedge sysclk);
    check("irq_rx_none", 32'(irqout), 32'd0);
    rx_pulse(8'h77);
    check("irq_rx_set", 32'(irqout), 32'd1);
    bus_read(32'h1C, v);
    check("irq_rx_data", v, 32'h77);
    check("irq_rx_lag", 32'(irqout), 32'd1);
    @(negedge sysclk);
    check("irq_rx_clr", 32'(irqout), 32'd0);

    // Reset during a transmission
    rx_pulse(8'h33);
    check("irq_pre_rst", 32'(irqout), 32'd1);
    bus_write(32'h18, 32'hA1);
    bus_write(32'h18, 32'hA2);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (tx_en === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge sysclk);
    end
    check("rst_tx_seen", 32'(seen), 32'd1);
    #2 reset = 1'b1;
    addr = BASE + 32'h20; rd = 1'b1;
    #1;
    check("rst_mid_tx_en", 32'(tx_en), 32'd0);
    check("rst_mid_irq", 32'(irqout), 32'd0);
    check("rst_mid_counts", 32'(rdata[23:8]), 32'd0);
    rd = 1'b0;
    @(negedge sysclk);
    reset = 1'b0;
    repeat (2) @(negedge sysclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
